// File: rtl/tmma_seq_pkg.sv
// Shared types and codes for the tmma issue sequencer.
package tmma_seq_pkg;
   localparam int TINST_TYPE_WIDTH     = 3;
   localparam int TLOAD_DATAW_WIDTH    = 4;
   localparam int TMMA_PRECISION_WIDTH = 2;
   localparam int TMMA_ADDR_WIDTH      = 32;

   // Code 0 and codes above POSTSTOREC are treated as unknown instructions.
   localparam logic [TINST_TYPE_WIDTH-1:0] TINST_TYPE_PRELOADA   = 3'd1;
   localparam logic [TINST_TYPE_WIDTH-1:0] TINST_TYPE_PRELOADC   = 3'd2;
   localparam logic [TINST_TYPE_WIDTH-1:0] TINST_TYPE_TMMA       = 3'd3;
   localparam logic [TINST_TYPE_WIDTH-1:0] TINST_TYPE_POSTSTOREC = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROW   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_e;

   function automatic logic tinst_known(input logic [TINST_TYPE_WIDTH-1:0] t);
      return (t == TINST_TYPE_PRELOADA) || (t == TINST_TYPE_PRELOADC) ||
             (t == TINST_TYPE_TMMA)     || (t == TINST_TYPE_POSTSTOREC);
   endfunction
endpackage

// File: rtl/tmma_seq_row_agen.sv
// Row counter and address accumulator for one instruction's row sweep.
module tmma_row_agen
   import tmma_seq_pkg::*;
#(
   parameter int ADDR_WIDTH = TMMA_ADDR_WIDTH,
   parameter int ARRAY_DIM  = 16,
   parameter int ROW_W      = $clog2(ARRAY_DIM)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  step,
   input  logic [ADDR_WIDTH-1:0] base,
   input  logic [ADDR_WIDTH-1:0] stride,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [ROW_W-1:0]      row,
   output logic                  first,
   output logic                  last
);
   logic [ADDR_WIDTH-1:0] stride_q;

   // Load restarts at row 0 from the base; each step advances one row,
   // address wrapping naturally at 2^ADDR_WIDTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr     <= '0;
         row      <= '0;
         stride_q <= '0;
      end else if (load) begin
         addr     <= base;
         row      <= '0;
         stride_q <= stride;
      end else if (step) begin
         addr <= addr + stride_q;
         row  <= row + 1'b1;
      end
   end

   assign first = (row == '0);
   assign last  = (row == ROW_W'(ARRAY_DIM - 1));
endmodule

// File: rtl/tmma_seq.sv
// Expands one tensor instruction into ARRAY_DIM scratchpad row requests
// with matching array beats, drains the array after TMMA, and pulses done.
module tmma_seq
   import tmma_seq_pkg::*;
#(
   parameter int ADDR_WIDTH   = TMMA_ADDR_WIDTH,
   parameter int ARRAY_DIM    = 16,
   parameter int DRAIN_CYCLES = 31,
   parameter int ROW_W        = $clog2(ARRAY_DIM)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            issue_tmma_valid_i,
   output logic                            issue_tmma_ready_o,
   input  logic [TINST_TYPE_WIDTH-1:0]     issue_tmma_type_i,
   input  logic [TLOAD_DATAW_WIDTH-1:0]    issue_tmma_data_width_i,
   input  logic [ADDR_WIDTH-1:0]           issue_tmma_addr0_i,
   input  logic [ADDR_WIDTH-1:0]           issue_tmma_addr1_i,
   input  logic [TMMA_PRECISION_WIDTH-1:0] issue_tmma_precision_i,
   input  logic                            issue_tmma_acc_i,
   output logic                            spad_req_valid_o,
   input  logic                            spad_req_ready_i,
   output logic                            spad_req_we_o,
   output logic [ADDR_WIDTH-1:0]           spad_req_addr_o,
   output logic                            arr_vld_o,
   output logic [TINST_TYPE_WIDTH-1:0]     arr_type_o,
   output logic [ROW_W-1:0]                arr_row_o,
   output logic                            arr_first_o,
   output logic                            arr_last_o,
   output logic                            arr_acc_o,
   output logic [TMMA_PRECISION_WIDTH-1:0] arr_prec_o,
   output logic [TLOAD_DATAW_WIDTH-1:0]    arr_dw_o,
   output logic                            busy_o,
   output logic                            done_vld_o,
   output logic [TINST_TYPE_WIDTH-1:0]     done_type_o,
   output logic                            done_err_o
);
   localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] DRAIN_INIT =
      (DRAIN_CYCLES > 0) ? CNT_W'(DRAIN_CYCLES - 1) : '0;

   seq_state_e                      state, nxt;
   logic [TINST_TYPE_WIDTH-1:0]     type_q;
   logic [TLOAD_DATAW_WIDTH-1:0]    dw_q;
   logic [TMMA_PRECISION_WIDTH-1:0] prec_q;
   logic                            acc_q, err_q;
   logic [CNT_W-1:0]                drain_cnt;
   logic [ADDR_WIDTH-1:0]           row_addr;
   logic [ROW_W-1:0]                row;
   logic                            row_first, row_last;
   logic                            issue_hs, spad_hs, sweep_end;

   assign issue_hs  = issue_tmma_valid_i && issue_tmma_ready_o;
   assign spad_hs   = spad_req_valid_o && spad_req_ready_i;
   assign sweep_end = spad_hs && row_last;

   tmma_row_agen #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .ARRAY_DIM (ARRAY_DIM),
      .ROW_W     (ROW_W)
   ) u_agen (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (issue_hs),
      .step  (spad_hs),
      .base  (issue_tmma_addr0_i),
      .stride(issue_tmma_addr1_i),
      .addr  (row_addr),
      .row   (row),
      .first (row_first),
      .last  (row_last)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= nxt;
   end

   // Next-state: unknown types skip straight to completion with an error.
   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE:  if (issue_hs)
                      nxt = tinst_known(issue_tmma_type_i) ? ST_ROW : ST_DONE;
         ST_ROW:   if (sweep_end)
                      nxt = (type_q == TINST_TYPE_TMMA && DRAIN_CYCLES != 0) ? ST_DRAIN : ST_DONE;
         ST_DRAIN: if (drain_cnt == '0) nxt = ST_DONE;
         ST_DONE:  nxt = ST_IDLE;
         default:  nxt = ST_IDLE;
      endcase
   end

   // Instruction fields are frozen at the accepting handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         type_q <= '0;
         dw_q   <= '0;
         prec_q <= '0;
         acc_q  <= 1'b0;
         err_q  <= 1'b0;
      end else if (issue_hs) begin
         type_q <= issue_tmma_type_i;
         dw_q   <= issue_tmma_data_width_i;
         prec_q <= issue_tmma_precision_i;
         acc_q  <= issue_tmma_acc_i;
         err_q  <= !tinst_known(issue_tmma_type_i);
      end
   end

   // Drain countdown armed on the final row handshake, reaching 0 on the last drain cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                  drain_cnt <= '0;
      else if (state == ST_ROW && sweep_end)       drain_cnt <= DRAIN_INIT;
      else if (state == ST_DRAIN && drain_cnt != 0) drain_cnt <= drain_cnt - 1'b1;
   end

   // Outputs; ready is held low while reset is asserted so every output reads 0.
   always_comb begin
      issue_tmma_ready_o = rst_n && (state == ST_IDLE);
      spad_req_valid_o   = (state == ST_ROW);
      spad_req_we_o      = (state == ST_ROW) && (type_q == TINST_TYPE_POSTSTOREC);
      spad_req_addr_o    = row_addr;
      arr_vld_o          = spad_hs;
      arr_type_o         = type_q;
      arr_row_o          = row;
      arr_first_o        = spad_hs && row_first;
      arr_last_o         = spad_hs && row_last;
      arr_acc_o          = acc_q;
      arr_prec_o         = prec_q;
      arr_dw_o           = dw_q;
      busy_o             = (state != ST_IDLE);
      done_vld_o         = (state == ST_DONE);
      done_type_o        = (state == ST_DONE) ? type_q : '0;
      done_err_o         = (state == ST_DONE) && err_q;
   end
endmodule

// File: tb/tb_tmma_seq.sv
// Scoreboard bench for tmma_seq with ARRAY_DIM=4, DRAIN_CYCLES=7.
module tb_tmma_seq;
   import tmma_seq_pkg::*;

   localparam int AD = 4;
   localparam int DC = 7;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        iv, irdy;
   logic [2:0]  ityp;
   logic [3:0]  idw;
   logic [31:0] ia0, ia1;
   logic [1:0]  iprec;
   logic        iacc;
   logic        sv, srdy, swe;
   logic [31:0] saddr;
   logic        avld, afirst, alast, aacc;
   logic [2:0]  atyp;
   logic [1:0]  arow, aprec;
   logic [3:0]  adw;
   logic        busy, dvld, derr;
   logic [2:0]  dtyp;

   tmma_seq #(.ADDR_WIDTH(32), .ARRAY_DIM(AD), .DRAIN_CYCLES(DC), .ROW_W(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .issue_tmma_valid_i(iv), .issue_tmma_ready_o(irdy),
      .issue_tmma_type_i(ityp), .issue_tmma_data_width_i(idw),
      .issue_tmma_addr0_i(ia0), .issue_tmma_addr1_i(ia1),
      .issue_tmma_precision_i(iprec), .issue_tmma_acc_i(iacc),
      .spad_req_valid_o(sv), .spad_req_ready_i(srdy), .spad_req_we_o(swe),
      .spad_req_addr_o(saddr),
      .arr_vld_o(avld), .arr_type_o(atyp), .arr_row_o(arow),
      .arr_first_o(afirst), .arr_last_o(alast), .arr_acc_o(aacc),
      .arr_prec_o(aprec), .arr_dw_o(adw),
      .busy_o(busy), .done_vld_o(dvld), .done_type_o(dtyp), .done_err_o(derr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [1:0]  row;
      logic        first, last, acc;
      logic [8:0]  fields;
      int          cyc;
   } beat_t;
   typedef struct {
      logic [2:0] typ;
      logic       err;
      int         cyc;
   } done_t;

   beat_t beat_q[$];
   done_t done_q[$];
   int    cyc = 0;
   int    vectors = 0;
   int    errs = 0;
   int    nbeats = 0;
   int    exp_beats = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic known(input logic [2:0] t);
      return t inside {3'd1, 3'd2, 3'd3, 3'd4};
   endfunction

   // Monitor: pops the scoreboard whenever the DUT presents a beat or a done pulse.
   always @(negedge clk) begin
      if (rst_n) begin
         if (avld || (sv && srdy)) chk("arr_vld_vs_hs", avld, sv && srdy);
         if (avld) begin
            nbeats++;
            if (beat_q.size() == 0) chk("unexpected_beat", 1, 0);
            else begin
               beat_t b;
               b = beat_q.pop_front();
               chk("beat_addr", saddr, b.addr);
               chk("beat_we", swe, b.we);
               chk("beat_row", arow, b.row);
               chk("beat_first_last", {afirst, alast}, {b.first, b.last});
               chk("beat_acc", aacc, b.acc);
               chk("beat_fields", {atyp, aprec, adw}, b.fields);
               chk("beat_cycle", cyc, b.cyc);
            end
         end
         if (dvld) begin
            if (done_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               done_t d;
               d = done_q.pop_front();
               chk("done_type", dtyp, d.typ);
               chk("done_err", derr, d.err);
               chk("done_cycle", cyc, d.cyc);
               chk("ready_low_at_done", irdy, 0);
            end
         end
      end
   end

   // Issue one instruction and push its expected beats and completion.
   task automatic issue(input logic [2:0] t, input logic [31:0] a0, input logic [31:0] st,
                        input logic acc, input logic [1:0] pr, input logic [3:0] dw,
                        input int stall_row, input int stall_len, output int c0);
      int n = 0;
      while (!irdy && n < 200) begin @(posedge clk); #1; n++; end
      if (!irdy) chk("issue_ready_timeout", 0, 1);
      iv = 1; ityp = t; ia0 = a0; ia1 = st; iacc = acc; iprec = pr; idw = dw;
      c0 = cyc;
      if (known(t)) begin
         for (int k = 0; k < AD; k++) begin
            beat_t b;
            b.addr   = a0 + st * k;
            b.we     = (t == 3'd4);
            b.row    = 2'(k);
            b.first  = (k == 0);
            b.last   = (k == AD - 1);
            b.acc    = acc;
            b.fields = {t, pr, dw};
            b.cyc    = c0 + 1 + k + ((k >= stall_row) ? stall_len : 0);
            beat_q.push_back(b);
         end
         exp_beats += AD;
         done_q.push_back('{typ: t, err: 1'b0,
                            cyc: c0 + AD + 1 + stall_len + ((t == 3'd3) ? DC : 0)});
      end else begin
         done_q.push_back('{typ: t, err: 1'b1, cyc: c0 + 1});
      end
      @(posedge clk); #1;
      // Scramble inputs to show that only the accepted values matter.
      iv = 0; ityp = 3'($urandom); ia0 = $urandom; ia1 = $urandom;
      iacc = 1'($urandom); iprec = 2'($urandom); idw = 4'($urandom);
   endtask

   task automatic wait_ready(input string name, input int exp_cyc);
      int n = 0;
      while (!irdy && n < 200) begin @(posedge clk); #1; n++; end
      chk(name, cyc, exp_cyc);
   endtask

   initial begin
      int c0;
      rst_n = 0; iv = 0; ityp = 0; idw = 0; ia0 = 0; ia1 = 0; iprec = 0; iacc = 0; srdy = 1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {irdy, sv, swe, saddr, avld, afirst, alast, busy, dvld, dtyp, derr}, 0);
      rst_n = 1;
      #1;
      chk("ready_after_reset", irdy, 1);
      @(posedge clk); #1;

      // PRELOADA, plain sweep
      issue(3'd1, 32'h1000, 32'h40, 0, 2'd1, 4'b0010, 99, 0, c0);
      wait_ready("preloada_ready_cycle", c0 + AD + 2);

      // TMMA with accumulate and drain
      issue(3'd3, 32'h2000, 32'h10, 1, 2'd2, 4'b0100, 99, 0, c0);
      repeat (7) begin @(posedge clk); #1; end
      chk("tmma_busy_in_drain", busy, 1);
      wait_ready("tmma_ready_cycle", c0 + AD + DC + 2);

      // POSTSTOREC with a 3-cycle stall on row 2
      issue(3'd4, 32'h3000, 32'h100, 0, 2'd3, 4'b1000, 2, 3, c0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      srdy = 0;
      repeat (3) begin
         chk("stall_valid_held", sv, 1);
         chk("stall_addr_held", saddr, 32'h3200);
         chk("stall_we_held", swe, 1);
         @(posedge clk); #1;
      end
      srdy = 1;
      wait_ready("poststore_ready_cycle", c0 + AD + 5);

      // Address wrap at 2^32
      issue(3'd2, 32'hFFFF_FFC0, 32'h40, 0, 2'd0, 4'b0001, 99, 0, c0);
      wait_ready("wrap_ready_cycle", c0 + AD + 2);

      // Unknown type code
      issue(3'd7, 32'h5000, 32'h40, 0, 2'd0, 4'b0001, 99, 0, c0);
      wait_ready("unknown_ready_cycle", c0 + 2);

      // Reset during row 2 of a PRELOADC
      issue(3'd2, 32'h6000, 32'h20, 1, 2'd1, 4'b0010, 99, 0, c0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 0;
      #1;
      chk("midreset_outputs", {irdy, sv, swe, saddr, avld, afirst, alast, busy, dvld, dtyp, derr}, 0);
      exp_beats -= beat_q.size();
      beat_q.delete();
      done_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
      #1;
      chk("ready_after_midreset", irdy, 1);
      @(posedge clk); #1;
      issue(3'd1, 32'h7000, 32'h8, 0, 2'd2, 4'b0100, 99, 0, c0);
      wait_ready("post_reset_ready_cycle", c0 + AD + 2);

      begin
         int n = 0;
         while ((beat_q.size() != 0 || done_q.size() != 0) && n < 100) begin
            @(posedge clk); n++;
         end
      end
      chk("scoreboard_drained", beat_q.size() + done_q.size(), 0);
      chk("total_beats", nbeats, exp_beats);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule

// File: doc/tmma_seq.md
Name: tmma_seq

Overview:
- Sequencer between the tmma issue channel of the reservation station and the scratchpad plus systolic array.
- Accepts one tensor instruction per handshake: PRELOADA, PRELOADC, TMMA or POSTSTOREC.
- Expands it into ARRAY_DIM row-granular scratchpad requests, each paired with an array control beat.
- Runs the array drain for TMMA and signals completion per instruction.

Parameters:
- ADDR_WIDTH, 32, address width of addr0/addr1 and scratchpad address.
- ARRAY_DIM, 16, array rows per instruction; power of two, at least 2.
- DRAIN_CYCLES, 31, array drain cycles after the last TMMA row (2*ARRAY_DIM-1).
- ROW_W, $clog2(ARRAY_DIM), row index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- issue_tmma_valid_i  in  1  instruction valid
- issue_tmma_ready_o  out  1  sequencer can accept
- issue_tmma_type_i  in  TINST_TYPE_WIDTH  instruction type
- issue_tmma_data_width_i  in  TLOAD_DATAW_WIDTH  one-hot element bytes, passed through
- issue_tmma_addr0_i  in  ADDR_WIDTH  row-0 scratchpad base
- issue_tmma_addr1_i  in  ADDR_WIDTH  row stride in bytes
- issue_tmma_precision_i  in  TMMA_PRECISION_WIDTH  passed to array
- issue_tmma_acc_i  in  1  TMMA accumulate into C (0 = overwrite)
- spad_req_valid_o  out  1  scratchpad request
- spad_req_ready_i  in  1  scratchpad accepts
- spad_req_we_o  out  1  1 = write (POSTSTOREC)
- spad_req_addr_o  out  ADDR_WIDTH  row address
- arr_vld_o  out  1  array beat, equals spad request handshake
- arr_type_o  out  TINST_TYPE_WIDTH  captured type
- arr_row_o  out  ROW_W  row index
- arr_first_o / arr_last_o  out  1  row 0 / row ARRAY_DIM-1
- arr_acc_o, arr_prec_o, arr_dw_o  out  1/PREC/DW  captured fields
- busy_o  out  1  state != IDLE
- done_vld_o  out  1  one-cycle completion pulse
- done_type_o  out  TINST_TYPE_WIDTH  completed type
- done_err_o  out  1  completed instruction had an unknown type

Behaviour:
- FSM states:
  - IDLE: issue_tmma_ready_o=1. On handshake, capture all fields; cur_addr=addr0; row=0. Known type -> ROW; unknown type -> DONE with err=1.
  - ROW: spad_req_valid_o=1, addr=cur_addr, we=(type==POSTSTOREC).
    - On handshake: arr_vld_o=1 in the same cycle; cur_addr+=stride, mod 2^ADDR_WIDTH wrap; row++.
    - After handshake on row ARRAY_DIM-1: TMMA -> DRAIN, other types -> DONE.
  - DRAIN: counter from DRAIN_CYCLES-1 down to 0; -> DONE when it reaches 0. With DRAIN_CYCLES=0, go straight from ROW to DONE.
  - DONE: done_vld_o=1 for one cycle, done_type_o=captured type -> IDLE.
- Request rules:
  - spad_req_valid_o, once raised, holds with address and we stable until ready.
  - ready_i is never required to be high while valid_o is low.
- Issue timing:
  - issue_tmma_ready_o is low outside IDLE, so at most one instruction is in flight.
  - Minimum inter-accept spacing is ARRAY_DIM+2 cycles for non-TMMA instructions.
- Latency with ready_i tied 1, accept at cycle 0:
  - rows at cycles 1..ARRAY_DIM;
  - done at ARRAY_DIM+1, or ARRAY_DIM+1+DRAIN_CYCLES for TMMA;
  - issue_tmma_ready_o high again the cycle after done.
- arr_first_o and arr_last_o are meaningful only when arr_vld_o=1. They are both 1 only if ARRAY_DIM==1, which is disallowed.
- Reset values: all outputs 0, except issue_tmma_ready_o=1 after reset release. State=IDLE, counters 0.
- Reset mid-instruction: the instruction is abandoned with no done pulse. The scratchpad side must treat an outstanding valid as withdrawn.
- Stride 0 is legal: all rows go to addr0.
- Captured fields ignore input changes after the accepting handshake.

Decomposition:
- Shared package/defines: TINST_TYPE_* codes and TINST_TYPE_WIDTH, TLOAD_DATAW_WIDTH, TMMA_PRECISION_WIDTH, ADDR_WIDTH, and the FSM state encoding.
- One sub-module, tmma_row_agen: holds the row counter and address accumulator, with load, step and last outputs.

Test Plan:
- PRELOADA, ARRAY_DIM=4, addr0=0x1000, stride 0x40, ready_i=1, accept at cycle 0:
  - reads at 0x1000/0x1040/0x1080/0x10C0 in cycles 1-4, we=0;
  - arr_first at cycle 1, arr_last at cycle 4;
  - done_vld at cycle 5, issue_tmma_ready_o=1 at cycle 6.
- TMMA, acc=1, DRAIN_CYCLES=7, ARRAY_DIM=4:
  - rows in cycles 1-4, arr_acc_o=1 on every beat;
  - busy through drain, done_vld at cycle 12 with done_type=TMMA.
- POSTSTOREC with ready_i low for 3 cycles on row 2:
  - we=1 on all rows; address and valid held stable during the stall;
  - exactly 4 arr_vld beats; done one cycle after the last handshake.
- Wrap: addr0=0xFFFFFFC0, stride 0x40, 32-bit -> addresses 0xFFFFFFC0, 0x00000000, 0x00000040, 0x00000080.
- Unknown type code accepted -> no spad request, done_vld=1 with done_err_o=1 at cycle 1.
- rst_n asserted during row 2 of a PRELOADC:
  - all outputs 0 immediately, no done pulse;
  - after release, ready_o=1 and a new PRELOADA runs from row 0.
